// File: rtl/ofifo_collect_pkg.sv
// ofifo_pkg: shared defaults and types for the output-side psum collector.
package ofifo_pkg;

  localparam int COL_DEF     = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int DEPTH_DEF   = 64;
  localparam int ADDR_BW_DEF = $clog2(DEPTH_DEF);

  // One column's partial sum, two's complement.
  typedef logic signed [PSUM_BW_DEF-1:0] psum_t;

  // Lane pointer: index bits plus one wrap bit on top.
  typedef logic [ADDR_BW_DEF:0] ptr_t;

endpackage

// File: rtl/ofifo_collect_if.sv
// ofifo_collect_if: south-edge psum capture and aligned read-out bundle.
// master drives psums/strobes/read request; slave is the collector itself.
interface ofifo_collect_if
  import ofifo_pkg::*;
#(
  parameter int col     = COL_DEF,
  parameter int psum_bw = PSUM_BW_DEF
);

  logic [psum_bw*col-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [psum_bw*col-1:0] out;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_full;
  logic                   o_overflow;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_ready, o_full, o_overflow
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_ready, o_full, o_overflow
  );

endinterface

// File: rtl/ofifo_collect_lane.sv
// ofifo_lane: one column's circular FIFO. Pointers carry a wrap bit above
// the index so full and empty are distinguishable without a counter.
// rd must only be asserted when the read is accepted across all lanes.
module ofifo_lane
  import ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int depth   = DEPTH_DEF,
  parameter int addr_bw = $clog2(depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full
);

  localparam logic [addr_bw:0] PTR_ONE = 1;

  logic [psum_bw-1:0] mem [depth];
  logic [addr_bw:0]   wptr;
  logic [addr_bw:0]   rptr;
  logic               wr_acc;

  assign empty = (wptr == rptr);
  assign full  = (wptr[addr_bw-1:0] == rptr[addr_bw-1:0]) &&
                 (wptr[addr_bw] != rptr[addr_bw]);

  // A full lane still takes a write when the same cycle pops its head.
  assign wr_acc = wr && (!full || rd);

  assign dout = mem[rptr[addr_bw-1:0]];

  // Storage write; intentionally not reset, only pointers define content.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[addr_bw-1:0]] <= din;
    end
  end

  // Pointer advance; natural binary overflow handles index wrap and wrap bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/ofifo_collect.sv
// ofifo_collect: absorbs the column skew of the MAC array south edge and
// presents one aligned psum row per accepted read, one cycle after the read.
// Build option OFIFO_RELU_EN: clamp negative popped words to zero on the
// way into the output register (no extra latency).
module ofifo_collect
  import ofifo_pkg::*;
#(
  parameter int col     = COL_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int depth   = DEPTH_DEF,
  parameter int addr_bw = $clog2(depth)
) (
  input  logic            clk,
  input  logic            reset,
  ofifo_collect_if.slave  bus
);

  logic [psum_bw-1:0]     head [col];
  logic [col-1:0]         lane_empty;
  logic [col-1:0]         lane_full;
  logic                   ready;
  logic                   rd_acc;
  logic                   drop;
  logic [psum_bw*col-1:0] nxt_out;
  logic [psum_bw*col-1:0] out_q;
  logic                   valid_q;
  logic                   overflow_q;

  for (genvar c = 0; c < col; c++) begin : g_lane
    ofifo_lane #(
      .psum_bw (psum_bw),
      .depth   (depth),
      .addr_bw (addr_bw)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .wr    (bus.wr[c]),
      .rd    (rd_acc),
      .din   (bus.in[psum_bw*c +: psum_bw]),
      .dout  (head[c]),
      .empty (lane_empty[c]),
      .full  (lane_full[c])
    );
  end

  // Flags come from current pointers only; a same-cycle write never counts.
  assign ready  = &(~lane_empty);
  assign rd_acc = bus.rd && ready;
  assign drop   = |(bus.wr & lane_full) && !rd_acc;

  // Gather lane heads into the packed row, optionally clamping negatives.
  always_comb begin
    nxt_out = '0;
    for (int c = 0; c < col; c++) begin
`ifdef OFIFO_RELU_EN
      nxt_out[psum_bw*c +: psum_bw] = head[c][psum_bw-1] ? '0 : head[c];
`else
      nxt_out[psum_bw*c +: psum_bw] = head[c];
`endif
    end
  end

  // Output row register: loads only on an accepted read, otherwise holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_acc;
      if (rd_acc) begin
        out_q <= nxt_out;
      end
    end
  end

  // Sticky overflow: any dropped write latches until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.out        = out_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_ready    = ready;
  assign bus.o_full     = |lane_full;
  assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_ofifo_collect.sv
// Bench for ofifo_collect: table-driven skewed fill plus directed corner
// sequences and a randomized phase, all scored against a queue-based model.
module tb_ofifo_collect;
  import ofifo_pkg::*;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;
  localparam int VW    = BW * COL;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ofifo_collect_if #(.col(COL), .psum_bw(BW)) bus ();

  ofifo_collect #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per lane plus the registered outputs.
  logic [BW-1:0] mq [COL][$];
  logic [VW-1:0] m_out;
  logic          m_valid;
  logic          m_ovf;

  typedef struct {
    logic [COL-1:0] wr;
    logic [VW-1:0]  din;
    logic           rd;
    logic           exp_ready;
    logic           exp_valid;
    logic [VW-1:0]  exp_out;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] relu(input logic [BW-1:0] v);
`ifdef OFIFO_RELU_EN
    return v[BW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic bit m_ready();
    for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_full();
    for (int c = 0; c < COL; c++) if (mq[c].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < COL; c++) mq[c].delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  function automatic logic [VW-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Apply one cycle of stimulus, advance the model, compare after the edge.
  task automatic cyc(input logic [COL-1:0] w, input logic [VW-1:0] d, input logic r);
    bit acc;
    bus.wr = w;
    bus.in = d;
    bus.rd = r;
    acc = r && m_ready();
    m_valid = acc;
    for (int c = 0; c < COL; c++) begin
      bit lf;
      logic [BW-1:0] v;
      lf = (mq[c].size() == DEPTH);
      if (acc) begin
        v = mq[c].pop_front();
        m_out[c*BW +: BW] = relu(v);
      end
      if (w[c]) begin
        if (!lf || acc) mq[c].push_back(d[c*BW +: BW]);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("out", bus.out, m_out);
    chk("o_valid", bus.o_valid, m_valid);
    chk("o_overflow", bus.o_overflow, m_ovf);
    chk("o_ready", bus.o_ready, m_ready());
    chk("o_full", bus.o_full, m_full());
  endtask

  // Asynchronous reset mid-cycle, leaving any in-flight read request applied.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_out", bus.out, '0);
    chk("rst_valid", bus.o_valid, 1'b0);
    chk("rst_overflow", bus.o_overflow, 1'b0);
    chk("rst_ready", bus.o_ready, 1'b0);
    chk("rst_full", bus.o_full, 1'b0);
    bus.wr = '0;
    bus.in = '0;
    bus.rd = 1'b0;
    model_reset();
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [VW-1:0] row;
    logic [VW-1:0] exp1;

    // Table: idle reads after reset, skewed fill, four aligned reads, one ignored read.
    for (int i = 0; i < 5; i++) begin
      tbl[i] = '{wr: '0, din: '0, rd: 1'b1, exp_ready: 1'b0, exp_valid: 1'b0, exp_out: '0};
    end
    for (int t = 0; t <= 10; t++) begin
      tbl[5+t] = '{wr: '0, din: '0, rd: 1'b0, exp_ready: (t >= 7), exp_valid: 1'b0, exp_out: '0};
      for (int c = 0; c < COL; c++) begin
        if (t - c >= 0 && t - c <= 3) begin
          tbl[5+t].wr[c] = 1'b1;
          tbl[5+t].din[c*BW +: BW] = BW'(16*c + (t - c));
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      tbl[16+k] = '{wr: '0, din: '0, rd: 1'b1, exp_ready: (k < 3), exp_valid: 1'b1, exp_out: '0};
      for (int c = 0; c < COL; c++) tbl[16+k].exp_out[c*BW +: BW] = BW'(16*c + k);
    end
    tbl[20] = '{wr: '0, din: '0, rd: 1'b1, exp_ready: 1'b0, exp_valid: 1'b0, exp_out: tbl[19].exp_out};

    bus.wr = '0;
    bus.in = '0;
    bus.rd = 1'b0;
    model_reset();
    reset = 1'b1;
    #2;
    chk("init_valid", bus.o_valid, 1'b0);
    chk("init_ready", bus.o_ready, 1'b0);
    chk("init_out", bus.out, '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].wr, tbl[i].din, tbl[i].rd);
      chk("tbl_ready", bus.o_ready, tbl[i].exp_ready);
      chk("tbl_valid", bus.o_valid, tbl[i].exp_valid);
      chk("tbl_out", bus.out, tbl[i].exp_out);
    end

    // Lane 0 to full, one dropped write, then the original 64 values in order.
    do_reset();
    for (int n = 0; n < DEPTH; n++) cyc(8'h01, VW'(n + 100), 1'b0);
    chk("fill_full", bus.o_full, 1'b1);
    chk("fill_no_ovf", bus.o_overflow, 1'b0);
    cyc(8'h01, VW'(16'h7777), 1'b0);
    chk("drop_ovf", bus.o_overflow, 1'b1);
    for (int n = 0; n < DEPTH; n++) cyc(8'hFE, rand_row(), 1'b0);
    for (int n = 0; n < DEPTH; n++) begin
      cyc('0, '0, 1'b1);
      chk("drain_lane0", bus.out[BW-1:0], VW'(n + 100));
    end

    // Full lanes with write and accepted read in the same cycle.
    do_reset();
    for (int n = 0; n < DEPTH; n++) cyc(8'hFF, rand_row(), 1'b0);
    cyc(8'hFF, rand_row(), 1'b1);
    chk("rw_full_full", bus.o_full, 1'b1);
    chk("rw_full_ovf", bus.o_overflow, 1'b0);
    chk("rw_full_valid", bus.o_valid, 1'b1);
    for (int n = 0; n < DEPTH; n++) cyc('0, '0, 1'b1);

    // Steady occupancy 3 across several pointer wraps.
    do_reset();
    for (int n = 0; n < 3; n++) cyc(8'hFF, rand_row(), 1'b0);
    for (int n = 0; n < 200; n++) cyc(8'hFF, rand_row(), 1'b1);
    for (int n = 0; n < 4; n++) cyc('0, '0, 1'b1);

    // Negative and positive word through the output path.
    do_reset();
    cyc(8'hFF, {COL{16'hFFF0}}, 1'b0);
    cyc(8'hFF, {COL{16'h0005}}, 1'b0);
    cyc('0, '0, 1'b1);
`ifdef OFIFO_RELU_EN
    exp1 = '0;
`else
    exp1 = {COL{16'hFFF0}};
`endif
    chk("relu_neg", bus.out, exp1);
    cyc('0, '0, 1'b1);
    chk("relu_pos", bus.out, {COL{16'h0005}});

    // Randomized traffic: fill-biased, then drain-biased.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      row = rand_row();
      if (n < 300) cyc(COL'($urandom), row, ($urandom_range(0, 3) == 0));
      else         cyc(COL'($urandom), row, ($urandom_range(0, 3) != 0));
    end

    // Reset while a read burst is in progress.
    do_reset();
    for (int n = 0; n < 4; n++) cyc(8'hFF, rand_row(), 1'b0);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b1);
    bus.rd = 1'b1;
    do_reset();
    cyc('0, '0, 1'b1);
    chk("post_rst_valid", bus.o_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
